keypad_scanner: RTL and testbench

- Upstream stage of the key edge-detection stage: drives the 4x4 matrix keypad rows, samples the columns, debounces each key and presents a clean 16-bit level vector `keyboard`.
- The edge-detection stage converts `keyboard` into one-cycle key-down pulses.
- Output bit `keyboard[row*4+col]` is 1 while key (row, col) is held after debounce.

---
 rtl/keypad_scanner.sv | 153 +++++++++++++++
 tb/tb_keypad_scanner.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one row at a time,
// synchronizes the column inputs, debounces every key on its own and
// presents a clean 16-bit level vector.
//
// Ports:
//   clock      system clock
//   reset      synchronous, active-high reset
//   row_n[3:0] row drive, active-low, exactly one row low at a time
//   col_n[3:0] raw column sense, active-low, asynchronous to clock
//   keyboard   debounced key levels, bit row*4+col, 1 = pressed
//   scan_tick  one-cycle pulse when a full 4-row scan is committed
//
// Parameters:
//   SCAN_DIV        clock cycles each row stays driven (4..65535)
//   DEBOUNCE_SCANS  consecutive disagreeing scans before a key flips (1..15)
//
// Optional feature macro: KEYPAD_GHOST_MASK_EN
//   When defined, a committed snapshot with three or more keys down is
//   discarded (keyboard and debounce counters hold; scan_tick still pulses).

module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 5000,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic        clock,
  input  logic        reset,
  output logic [3:0]  row_n,
  input  logic [3:0]  col_n,
  output logic [15:0] keyboard,
  output logic        scan_tick
);

  localparam int unsigned DIV_W = 16;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned KEYS  = 16;
  localparam int unsigned COLS  = 4;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  // A key flips when its counter is already at DEBOUNCE_SCANS-1.
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_SCANS - 1);

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_row;
  logic [3:0]       r_row_n;
  logic [KEYS-1:0]  r_raw;
  logic [CNT_W-1:0] r_cnt [KEYS];
  logic [KEYS-1:0]  r_keyboard;
  logic             r_scan_tick;
  logic             r_commit;

  logic             w_row_end;
  logic [DIV_W-1:0] w_div_next;
  logic [1:0]       w_row_next;
  logic [3:0]       w_row_n_next;
  logic [KEYS-1:0]  w_raw_next;
  logic             w_commit_next;
  logic             w_ghost;
  logic             w_apply;
  logic [CNT_W-1:0] w_cnt_next [KEYS];
  logic [KEYS-1:0]  w_kb_next;

  assign row_n     = r_row_n;
  assign keyboard  = r_keyboard;
  assign scan_tick = r_scan_tick;

  // Row divider, row sequencing and per-row snapshot capture.
  always_comb begin
    w_row_end     = (r_div == DIV_LAST);
    w_div_next    = r_div + DIV_W'(1);
    w_row_next    = r_row;
    w_row_n_next  = r_row_n;
    w_raw_next    = r_raw;
    w_commit_next = 1'b0;
    if (w_row_end) begin
      w_div_next    = '0;
      w_row_next    = r_row + 2'd1;
      w_row_n_next  = ~(4'b0001 << w_row_next);
      w_commit_next = (r_row == 2'd3);
      for (int j = 0; j < int'(COLS); j++) begin
        w_raw_next[{r_row, 2'(j)}] = ~r_sync2[j];
      end
    end
  end

  // Snapshot rejection when too many keys are down at once.
`ifdef KEYPAD_GHOST_MASK_EN
  logic [4:0] w_pop;
  always_comb begin
    w_pop = '0;
    for (int k = 0; k < int'(KEYS); k++) begin
      w_pop = w_pop + 5'(r_raw[k]);
    end
    w_ghost = (w_pop >= 5'd3);
  end
`else
  always_comb begin
    w_ghost = 1'b0;
  end
`endif

  // Per-key debounce applied one cycle after the row-3 sample.
  always_comb begin
    w_apply   = r_commit && !w_ghost;
    w_kb_next = r_keyboard;
    for (int k = 0; k < int'(KEYS); k++) begin
      w_cnt_next[k] = r_cnt[k];
      if (w_apply) begin
        if (r_raw[k] == r_keyboard[k]) begin
          w_cnt_next[k] = '0;
        end else if (r_cnt[k] == DB_LAST) begin
          w_cnt_next[k] = '0;
          w_kb_next[k]  = ~r_keyboard[k];
        end else begin
          w_cnt_next[k] = r_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1     <= 4'b1111;
      r_sync2     <= 4'b1111;
      r_div       <= '0;
      r_row       <= 2'd0;
      r_row_n     <= 4'b1110;
      r_raw       <= '0;
      r_keyboard  <= '0;
      r_scan_tick <= 1'b0;
      r_commit    <= 1'b0;
      for (int k = 0; k < int'(KEYS); k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      r_sync1     <= col_n;
      r_sync2     <= r_sync1;
      r_div       <= w_div_next;
      r_row       <= w_row_next;
      r_row_n     <= w_row_n_next;
      r_raw       <= w_raw_next;
      r_keyboard  <= w_kb_next;
      r_scan_tick <= r_commit;
      r_commit    <= w_commit_next;
      for (int k = 0; k < int'(KEYS); k++) begin
        r_cnt[k] <= w_cnt_next[k];
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized and directed key patterns, held per scan,
// checked against a per-key run-length debounce model of the keypad.

module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 3;
  localparam int SCAN_CYC = 4 * SCAN_DIV;
  localparam int N_RAND   = 60;
  localparam int RST_SCAN = 34;
  localparam int RST_RAND = 75;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] keyboard;
  logic        scan_tick;

  logic [15:0] pressed = '0;

  int checks = 0;
  int errors = 0;

  logic [15:0] kb_m;
  int          run_m [16];

  always #5 clock = ~clock;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB)) dut (
    .clock     (clock),
    .reset     (reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .keyboard  (keyboard),
    .scan_tick (scan_tick)
  );

  // Ideal keypad: a pressed key pulls its column low while its row is driven.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      col_n[j] = 1'b1;
      for (int r = 0; r < 4; r++) begin
        if (!row_n[r] && pressed[r*4+j]) col_n[j] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    kb_m = '0;
    for (int k = 0; k < 16; k++) run_m[k] = 0;
  endtask

  // A key flips after DB consecutive scans disagreeing with its level.
  task automatic model_commit(input logic [15:0] snap);
    bit skip = 0;
`ifdef KEYPAD_GHOST_MASK_EN
    skip = ($countones(snap) >= 3);
`endif
    if (!skip) begin
      for (int k = 0; k < 16; k++) begin
        if (snap[k] == kb_m[k]) run_m[k] = 0;
        else begin
          run_m[k] = run_m[k] + 1;
          if (run_m[k] == DB) begin
            kb_m[k]  = ~kb_m[k];
            run_m[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_row_n", 32'(row_n), 32'h e);
    check("rst_keyboard", 32'(keyboard), 32'h0);
    check("rst_scan_tick", 32'(scan_tick), 32'h0);
    reset = 1'b0;
    model_reset();
  endtask

  // Waits for scan_tick, checking keyboard holds meanwhile and the tick spacing.
  task automatic wait_tick(input int exp_gap);
    int n = 0;
    bit seen = 0;
    while (n < 3 * SCAN_CYC && !seen) begin
      @(negedge clock);
      n++;
      if (scan_tick) seen = 1;
      else check("kb_hold", 32'(keyboard), 32'(kb_m));
    end
    if (!seen) check("tick_timeout", 32'h0, 32'h1);
    else check("tick_gap", 32'(n), 32'(exp_gap));
  endtask

  logic [15:0] dir [$] = '{
    16'h0040, 16'h0040, 16'h0040, 16'h0040,
    16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0040, 16'h0040, 16'h0000, 16'h0000, 16'h0000,
    16'h0040, 16'h0040, 16'h0040,
    16'h0000, 16'h0000, 16'h0040, 16'h0000, 16'h0000, 16'h0040,
    16'h0000, 16'h0000, 16'h0000,
    16'h0013, 16'h0013, 16'h0013, 16'h0013,
    16'h0000, 16'h0000, 16'h0000,
    16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
    16'h0000, 16'h0000, 16'h0000
  };

  initial begin
    logic [15:0] vec;
    logic [3:0]  exp_row;
    int          gap;
    int          n_keys;

    // Row sequencing and first tick timing after reset.
    pressed = '0;
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      exp_row = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      check("row_seq", 32'(row_n), 32'(exp_row));
      check("tick_seq", 32'(scan_tick), 32'((k >= SCAN_CYC + 1) && (k % SCAN_CYC == 1)));
    end

    // One key pattern per scan, each held for that whole scan.
    do_reset();
    @(negedge clock);
    check("post_rst_row_n", 32'(row_n), 32'h e);
    gap = SCAN_CYC;
    vec = '0;
    for (int s = 0; s < dir.size() + N_RAND; s++) begin
      if (s < dir.size()) begin
        vec = dir[s];
      end else if ($urandom_range(99) >= 60) begin
        n_keys = $urandom_range(3);
        vec = '0;
        for (int i = 0; i < n_keys; i++) vec = vec | (16'h0001 << $urandom_range(15));
      end
      pressed = vec;
      if (s == RST_SCAN || s == RST_RAND) begin
        repeat ((s == RST_SCAN) ? 9 : $urandom_range(15, 1)) @(negedge clock);
        do_reset();
        @(negedge clock);
        check("post_rst_row_n", 32'(row_n), 32'h e);
      end
      wait_tick(gap);
      gap = SCAN_CYC;
      model_commit(vec);
      check("kb_commit", 32'(keyboard), 32'(kb_m));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
